// File: rtl/dac_playback_ctrl_pkg.sv
// Shared types and default widths for the DAC playback controller.
package dac_playback_ctrl_pkg;

    localparam int unsigned DAC_DW        = 14;
    localparam int unsigned CNT_W_DEF     = 32;
    localparam int unsigned DIV_W_DEF     = 16;
    localparam logic [DAC_DW-1:0] IDLE_CODE_DEF = 14'h2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/dac_playback_ctrl_if.sv
// FIFO read port between the playback controller (master) and the waveform FIFO (slave).
interface dac_playback_ctrl_if #(
    parameter int unsigned DW = dac_playback_ctrl_pkg::DAC_DW
) ();

    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_almost_empty;

    modport master (
        output fifo_rd_en,
        input  fifo_data,
        input  fifo_empty,
        input  fifo_almost_empty
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_data,
        output fifo_empty,
        output fifo_almost_empty
    );

endinterface

// File: rtl/dac_playback_ctrl_rate_tick.sv
// Sample-rate divider: tick on the first enabled cycle, then every rate_div+1 clocks.
module dac_playback_ctrl_rate_tick #(
    parameter int unsigned DIV_W = dac_playback_ctrl_pkg::DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_c = !clr && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == rate_div)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_playback_ctrl.sv
// DAC playback sequencer: paces FIFO reads and drives the AD9744 data bus.
// Build option DAC_HOLD_LAST_EN: when defined, the last played sample stays on dac_data in IDLE.
module dac_playback_ctrl
    import dac_playback_ctrl_pkg::*;
#(
    parameter int unsigned   DW        = DAC_DW,
    parameter int unsigned   CNT_W     = CNT_W_DEF,
    parameter int unsigned   DIV_W     = DIV_W_DEF,
    parameter logic [DW-1:0] IDLE_CODE = DW'(IDLE_CODE_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_continuous,
    input  logic [CNT_W-1:0]    cfg_burst_len,
    input  logic [DIV_W-1:0]    cfg_rate_div,
    input  logic                underrun_clr,
    dac_playback_ctrl_if.master fifo,
    output logic [DW-1:0]       dac_data,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    state_e state_q, state_d;

    logic             cont_q;
    logic [CNT_W-1:0] len_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;

    logic accept_c;
    logic run_c;
    logic tick_c;
    logic tick_clr_c;
    logic rd_c;
    logic empty_tick_c;
    logic last_c;

    // Stop outranks a same-cycle tick: neither a read nor an underrun is raised.
    assign accept_c     = (state_q == ST_IDLE) && start && !stop;
    assign run_c        = (state_q == ST_RUN);
    assign tick_clr_c   = !run_c;
    assign rd_c         = run_c && tick_c && !stop && !fifo.fifo_empty;
    assign empty_tick_c = run_c && tick_c && !stop && fifo.fifo_empty;
    assign last_c       = !cont_q && ((cnt_q + CNT_W'(1)) == len_q);

    assign fifo.fifo_rd_en = rd_c;

    dac_playback_ctrl_rate_tick #(
        .DIV_W (DIV_W)
    ) u_rate_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr_c),
        .rate_div (div_q),
        .tick_c   (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (stop || (!cont_q && (len_q == '0))) state_d = ST_FLUSH;
                else if (!fifo.fifo_almost_empty)       state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop || (rd_c && last_c)) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Config snapshot, sample counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q   <= 1'b0;
            len_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            dac_data <= IDLE_CODE;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (accept_c) begin
                cont_q <= cfg_continuous;
                len_q  <= cfg_burst_len;
                div_q  <= cfg_rate_div;
                cnt_q  <= '0;
            end else if (rd_c) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end

            pend_q <= rd_c;

            if (pend_q) begin
                dac_data <= fifo.fifo_data;
`ifndef DAC_HOLD_LAST_EN
            end else if (state_q == ST_IDLE) begin
                dac_data <= IDLE_CODE;
`endif
            end

            busy <= (state_d != ST_IDLE);
            done <= (state_q == ST_FLUSH);

            if (empty_tick_c)      underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

endmodule
